// File: rtl/core_pkg.sv
// core_pkg: state encodings and default constants shared by the core sequencer.
package core_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5,
    S_PAUSE  = 3'd6
  } state_t;
  localparam logic [31:0] HALT_OPC_ALL = '1;
endpackage

// File: rtl/btn_sync.sv
// btn_sync: 2-flop synchroniser plus rising-edge pulse; a level already high at reset
// release is ignored until the input has been seen low.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);
  logic r_meta, r_sync, r_prev, r_armed;
  logic [1:0] r_vld;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_vld   <= 2'b00;
    end else begin
      r_meta  <= i_btn;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_vld   <= {r_vld[0], 1'b1};
      r_armed <= r_armed | (r_vld[1] & ~r_sync);
    end
  assign o_pulse = r_sync & ~r_prev & r_armed;
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: fetch/wait/decode/execute control FSM with retired-instruction count.
// Define SINGLE_STEP_EN to pause after every EXEC until the next start press.
module core_sequencer
  import core_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int OPC_W    = 4,
  parameter int MEM_WAIT = 1,
  parameter logic [OPC_W-1:0] HALT_OPC = HALT_OPC_ALL[OPC_W-1:0],
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] ir_in,
  output logic [2:0]        state,
  output logic              fetch_en,
  output logic              ir_load,
  output logic              exec_en,
  output logic              pc_inc,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_cnt
);
  localparam logic [3:0] WAIT_LD = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;
  logic [2:0] r_state, w_next;
  logic [3:0] r_wait;
  logic [CNT_W-1:0] r_cnt;
  logic [OPC_W-1:0] w_opc;
  logic w_start, w_unused;
  assign w_opc = ir_in[DATA_W-1 -: OPC_W];
  assign w_unused = ^ir_in;
  btn_sync u_start (.clk(clk), .rst(rst), .i_btn(start), .o_pulse(w_start));
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = w_start ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = (MEM_WAIT > 0) ? S_WAIT : S_DECODE;
      S_WAIT:   w_next = (r_wait == 4'd0) ? S_DECODE : S_WAIT;
      S_DECODE: w_next = (w_opc == HALT_OPC) ? S_HALT : S_EXEC;
`ifdef SINGLE_STEP_EN
      S_EXEC:   w_next = S_PAUSE;
      S_PAUSE:  w_next = w_start ? S_FETCH : S_PAUSE;
`else
      S_EXEC:   w_next = S_FETCH;
`endif
      S_HALT:   w_next = w_start ? S_IDLE : S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end
  always_comb begin
    state    = r_state;
    fetch_en = r_state == S_FETCH;
    ir_load  = r_state == S_DECODE;
    exec_en  = r_state == S_EXEC;
    pc_inc   = r_state == S_EXEC;
    halted   = r_state == S_HALT;
  end
  // WAIT exits on zero, so loading MEM_WAIT-1 gives exactly MEM_WAIT WAIT cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) r_wait <= 4'd0;
    else if (r_state == S_FETCH) r_wait <= WAIT_LD;
    else if (r_state == S_WAIT && r_wait != 4'd0) r_wait <= r_wait - 4'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (r_state == S_EXEC) r_cnt <= r_cnt + 1'b1;
  assign instr_cnt = r_cnt;
endmodule
